// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg
//   Shared constants and types for the two-master memory bus arbiter.
//   XLEN       : address/data width of the SoC valid/ready memory bus
//   WEN_W      : byte write-enable width (one bit per byte of XLEN)
//   ERR_DATA_DEF : default read data returned when the watchdog aborts
//   state_t    : arbiter FSM states (IDLE, BUSY0, BUSY1)
//   grant_of() : one-hot owner vector for a given FSM state
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int WEN_W = 4;

  localparam logic [XLEN-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  // Bit 0 is master 0, bit 1 is master 1; all-zero while no transfer is open.
  function automatic logic [1:0] grant_of(state_t st);
    case (st)
      BUSY0:   return 2'b01;
      BUSY1:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
//   One valid/ready memory bus link. The same interface type is used for
//   the two upstream masters and for the downstream slave fabric.
//   valid : request held by the initiator until ready
//   ready : single-cycle completion from the responder
//   addr  : byte address
//   wdata : write data
//   wen   : byte write enables, all-zero means read
//   rdata : read data, meaningful in the ready cycle
//   Modports:
//     master : the initiator side (drives valid/addr/wdata/wen)
//     slave  : the responder side (drives ready/rdata)
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic             valid;
  logic             ready;
  logic [XLEN-1:0]  addr;
  logic [XLEN-1:0]  wdata;
  logic [WEN_W-1:0] wen;
  logic [XLEN-1:0]  rdata;

  modport master (
    output valid,
    output addr,
    output wdata,
    output wen,
    input  ready,
    input  rdata
  );

  modport slave (
    input  valid,
    input  addr,
    input  wdata,
    input  wen,
    output ready,
    output rdata
  );

endinterface

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// ---------------------------------------------------------------------------
// bus_watchdog
//   Counts cycles of an open bus transfer and raises a strobe in the last
//   permitted cycle so the owner can terminate the access itself.
//   clk     : system clock
//   resetn  : synchronous, active-low reset
//   clr     : holds the counter at zero (asserted while the bus is idle)
//   en      : counts one cycle per clock while a transfer is open
//   timeout : high during the TIMEOUT-th cycle of an open transfer
//   TIMEOUT must lie in 2 .. 2**TO_W-1 so TIMEOUT-1 fits the counter.
// ---------------------------------------------------------------------------
module bus_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  // The counter is zero in the first busy cycle because the arbiter always
  // spends at least one idle cycle (clr) before opening a new transfer.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign timeout = en && (cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Two-master, one-slave arbiter for the SoC valid/ready memory bus.
//   Master 0 is the CPU core, master 1 the DMA/debug loader; the slave side
//   is the address-decoded fabric (no decode is done here).
//   Round-robin between simultaneous requesters, one transfer outstanding,
//   a forced idle cycle after every transfer, and a watchdog that ends an
//   unanswered access with ERR_DATA and a bus_err pulse.
//
//   Ports:
//     clk     : system clock
//     resetn  : synchronous, active-low reset
//     m0      : master 0 link (arbiter is the responder)
//     m1      : master 1 link (arbiter is the responder)
//     s       : downstream link (arbiter is the initiator)
//     bus_err : one-cycle pulse when the watchdog aborts a transfer
//     grant   : one-hot current owner, 00 while idle
//
//   Parameters:
//     TIMEOUT  : busy cycles allowed without s.ready before abort
//     TO_W     : watchdog counter width
//     ERR_DATA : read data returned to the master on abort
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int              TIMEOUT  = 64,
  parameter int              TO_W     = 7,
  parameter logic [XLEN-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  mem_bus_arbiter_if.slave        m0,
  mem_bus_arbiter_if.slave        m1,
  mem_bus_arbiter_if.master       s,
  output logic                    bus_err,
  output logic [1:0]              grant
);

  state_t state;
  state_t state_nxt;
  logic   last_owner;
  logic   last_owner_nxt;
  logic   busy;
  logic   timeout;
  logic   abort;

  // Read data handed back to the owner: the slave's data on a real
  // completion, ERR_DATA only when the watchdog ends the transfer alone.
  function automatic logic [XLEN-1:0] resp_data(input logic            slv_ready,
                                                input logic            to,
                                                input logic [XLEN-1:0] slv_rdata);
    return (to && !slv_ready) ? ERR_DATA : slv_rdata;
  endfunction

  assign busy  = (state != IDLE);
  // A ready in the timeout cycle is a normal completion, not an abort.
  assign abort = timeout && !s.ready;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (!busy),
    .en      (busy),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      last_owner <= 1'b1;   // master 0 wins the first tie after reset
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Next-state logic. BUSYx always returns to IDLE, which gives the
  // mandatory turnaround cycle with s.valid low between transfers.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        if (m0.valid && m1.valid) begin
          state_nxt = last_owner ? BUSY0 : BUSY1;
        end else if (m0.valid) begin
          state_nxt = BUSY0;
        end else if (m1.valid) begin
          state_nxt = BUSY1;
        end
      end
      BUSY0: begin
        if (s.ready || timeout) begin
          state_nxt      = IDLE;
          last_owner_nxt = 1'b0;
        end
      end
      BUSY1: begin
        if (s.ready || timeout) begin
          state_nxt      = IDLE;
          last_owner_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bus steering. Everything here is combinational from the registered
  // state, so in IDLE (and therefore right after reset) all outputs are 0.
  always_comb begin
    s.valid  = 1'b0;
    s.addr   = '0;
    s.wdata  = '0;
    s.wen    = '0;
    m0.ready = 1'b0;
    m0.rdata = '0;
    m1.ready = 1'b0;
    m1.rdata = '0;
    bus_err  = 1'b0;
    grant    = grant_of(state);
    case (state)
      BUSY0: begin
        s.valid  = 1'b1;
        s.addr   = m0.addr;
        s.wdata  = m0.wdata;
        s.wen    = m0.wen;
        m0.ready = s.ready || timeout;
        m0.rdata = resp_data(s.ready, timeout, s.rdata);
        bus_err  = abort;
      end
      BUSY1: begin
        s.valid  = 1'b1;
        s.addr   = m1.addr;
        s.wdata  = m1.wdata;
        s.wen    = m1.wen;
        m1.ready = s.ready || timeout;
        m1.rdata = resp_data(s.ready, timeout, s.rdata);
        bus_err  = abort;
      end
      default: begin
      end
    endcase
  end

endmodule
